// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounced input event path.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned MAX_CHAN_W              = 5;

    typedef struct packed {
        logic [MAX_CHAN_W-1:0] chan;
        logic                  level;
    } evt_t;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: pad synchronizer, stability counter, stable level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_change,
    output logic o_new_level
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic w_s;
    logic w_differs;
    logic w_accept;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_s != r_stable);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_rise <= w_accept && w_s;
            r_fall <= w_accept && !w_s;
            // Any sample matching the stable level restarts the count.
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_stable <= w_s;
            end
        end
    end

    assign o_level     = r_stable;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_change    = w_accept;
    assign o_new_level = w_s;

endmodule

// File: rtl/input_debounce_events.sv
// Debounced pad inputs with a one-slot-per-channel event queue served lowest index first.
module input_debounce_events
    import debounce_pkg::*;
#(
    parameter int unsigned N_INPUTS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    localparam int unsigned CHAN_W         = chan_width(N_INPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] btn_in,
    output logic [N_INPUTS-1:0] level_out,
    output logic [N_INPUTS-1:0] rise_pulse,
    output logic [N_INPUTS-1:0] fall_pulse,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CHAN_W-1:0]   evt_chan,
    output logic                evt_level,
    output logic [N_INPUTS-1:0] overflow,
    input  logic                clr_overflow
);

    logic [N_INPUTS-1:0] r_pending;
    logic [N_INPUTS-1:0] r_plevel;
    logic [N_INPUTS-1:0] r_overflow;

    logic [N_INPUTS-1:0] w_change;
    logic [N_INPUTS-1:0] w_new_level;
    logic [N_INPUTS-1:0] w_pending_d;
    logic [N_INPUTS-1:0] w_plevel_d;
    logic [N_INPUTS-1:0] w_ovf_set;
    logic [N_INPUTS-1:0] w_overflow_d;
    logic [CHAN_W-1:0]   w_sel;
    logic                w_take;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_btn       (btn_in[g]),
            .o_level     (level_out[g]),
            .o_rise      (rise_pulse[g]),
            .o_fall      (fall_pulse[g]),
            .o_change    (w_change[g]),
            .o_new_level (w_new_level[g])
        );
    end

    // Scan downwards so the lowest pending index wins.
    always_comb begin
        w_sel = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = CHAN_W'(i);
            end
        end
    end

    assign evt_valid = |r_pending;
    assign evt_chan  = w_sel;
    assign evt_level = r_plevel[w_sel];
    assign w_take    = evt_valid && evt_ready;

    always_comb begin
        w_pending_d = r_pending;
        w_plevel_d  = r_plevel;
        w_ovf_set   = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (w_take && (w_sel == CHAN_W'(i))) begin
                w_pending_d[i] = 1'b0;
            end
            // A new change beats a same-cycle consume; only an unconsumed slot overflows.
            if (w_change[i]) begin
                w_pending_d[i] = 1'b1;
                w_plevel_d[i]  = w_new_level[i];
                w_ovf_set[i]   = r_pending[i] && !(w_take && (w_sel == CHAN_W'(i)));
            end
        end
    end

    assign w_overflow_d = clr_overflow ? '0 : (r_overflow | w_ovf_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_plevel   <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= w_pending_d;
            r_plevel   <= w_plevel_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: doc/input_debounce_events.md
Name: input_debounce_events

Overview:
- Input-side counterpart to the counter/LED output path: takes N asynchronous pad inputs (buttons/switches arriving through input buffers) and synchronizes them to `clk`.
- Debounces each channel with a stability counter and generates one-cycle rise/fall pulses.
- Queues one change event per channel and presents events on a valid/ready port, lowest channel index first.
- Sits between the top-level input pins and control logic, such as a consumer that steers LED patterns.

Parameters:
- N_INPUTS, 4: number of independent input channels (1..32).
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized value must differ from the stable level before it is accepted (>=2).
- SYNC_STAGES, 2: synchronizer flop depth (>=2).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  N_INPUTS  raw asynchronous pad inputs.
- level_out  output  N_INPUTS  debounced stable level per channel.
- rise_pulse  output  N_INPUTS  1-cycle pulse when level_out goes 0->1.
- fall_pulse  output  N_INPUTS  1-cycle pulse when level_out goes 1->0.
- evt_valid  output  1  at least one channel has a pending event.
- evt_ready  input  1  consumer accepts the event this cycle.
- evt_chan  output  CHAN_W  index of the presented channel; CHAN_W = max(1, clog2(N_INPUTS)).
- evt_level  output  1  new level of the presented channel.
- overflow  output  N_INPUTS  sticky: an event was overwritten before it was consumed.
- clr_overflow  input  1  synchronous pulse; clears all overflow bits.

Behaviour:
- Reset (async assert on rst_n low, sync release): all of the following are 0.
  - Synchronizer flops, stable levels, counters.
  - level_out, rise_pulse, fall_pulse, pending, overflow.
  - evt_valid, evt_chan, evt_level.
- Reset mid-operation discards all pending events and counters. No pulses are emitted on reset release, even when btn_in is 1.
- Synchronizer: SYNC_STAGES flop chain per bit; the last stage is `s[i]`.
- Debounce, per channel, every cycle:
  - If s[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= s[i], cnt[i] <= 0, and rise or fall pulse asserted the same cycle stable updates.
  - Else: cnt[i] <= cnt[i]+1.
- Any glitch back to stable[i] restarts the count from 0. Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
- Latency: a clean step on btn_in sampled at edge k reaches level_out at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Pulses are registered and coincide with the level_out change. Exactly one pulse per accepted change; never rise and fall together.
- Pending queue, one slot per channel:
  - On a change: pending[i] <= 1, plevel[i] <= new level.
  - If pending[i] is already 1 and is not consumed this cycle: plevel is overwritten with the newest level and overflow[i] <= 1.
- Event port:
  - evt_valid = |pending.
  - evt_chan = lowest i with pending[i]; evt_level = plevel[evt_chan]. Both are combinational from registers.
  - Transfer on evt_valid && evt_ready: pending[evt_chan] cleared at the edge.
  - evt_ready while evt_valid=0 has no effect.
- Simultaneous consume and new change on the same channel: pending stays 1 with the new level, no overflow.
- Simultaneous changes on several channels in one cycle: all become pending, served in index order, one per accepted transfer (max throughput 1 event/cycle).
- evt_chan/evt_level are stable while evt_valid=1 and evt_ready=0, unless a lower-index channel becomes pending, which preempts it (permitted, documented).
- clr_overflow has priority over a same-cycle overflow set: the result is 0.

Decomposition:
- Shared package, debounce_pkg:
  - Localparam function computing CHAN_W.
  - Typedef for the event record {chan, level}.
  - Default constants DEBOUNCE_CYCLES_DEFAULT = 16, SYNC_STAGES_DEFAULT = 2.
- Sub-module debounce_channel: one channel's synchronizer, counter, stable register and pulse generation. Instantiated N_INPUTS times via generate.
- The top holds the pending/plevel/overflow registers and the priority encoder.

Test Plan (N_INPUTS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset with btn_in=4'b1111 held, release rst_n:
  - No pulses on release.
  - level_out=4'b1111 after 2+4-1 cycles, with rise_pulse=4'b1111 for exactly one cycle.
  - evt_valid=1, evt_chan=0, evt_level=1.
- Clean step on channel 2 (0->1), evt_ready=1:
  - level_out[2] rises 5 cycles after the sampling edge; rise_pulse[2] lasts one cycle.
  - One transfer with chan=2, level=1, then evt_valid=0.
- Bounce on channel 1 (toggle 1,0,1,0 every cycle, then hold 1):
  - No change until 4 consecutive stable synchronized cycles.
  - Exactly one rise_pulse[1]; no fall_pulse.
- Overflow: evt_ready=0 on channel 3; press, then release (each held 8 cycles):
  - overflow[3]=1, evt_level=0.
  - clr_overflow -> overflow=0; raising evt_ready yields a single event (chan=3, level=0).
- Priority and ordering: channels 0 and 3 change in the same cycle, evt_ready=1:
  - Event chan=0 is accepted first, then chan=3 next cycle, then evt_valid=0.
- Mid-operation reset: assert rst_n=0 while cnt[2]=2 and pending[1]=1:
  - All outputs are 0 immediately (async).
  - After release, no stale event or pulse appears.
